// File: rtl/calc_operand_capture.sv
// calc_operand_capture
// Front-end for the 4-bit signed calculator. Raw switches, opcode lines and
// the ENTER pushbutton are brought into the CLOCK_50 domain with two-flop
// synchronisers. ENTER is then debounced. Each debounced press loads
// A_OUT/B_OUT/OP_OUT together and raises VALID for exactly one cycle. BUSY
// stays high from the capture until the debounced release.
//
// Optional feature: define CALC_REPEAT_EN to enable auto-repeat. While ENTER
// is held, the outputs are re-sampled and VALID pulses every REPEAT_CYCLES
// cycles. When the macro is undefined the repeat logic is not built.
//
// Debug visibility: the FSM state is held in r_state (type state_t).

module calc_operand_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] SW,
    input  logic [2:0] KEY,
    input  logic       ENTER_N,
    output logic [3:0] A_OUT,
    output logic [3:0] B_OUT,
    output logic [2:0] OP_OUT,
    output logic       VALID,
    output logic       BUSY
);

    // Both counters must be able to reach their terminal value without wrapping.
    if (CNT_W < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        DEBOUNCE_CYCLES > (2 ** CNT_W) || REPEAT_CYCLES > (2 ** CNT_W)) begin : g_bad_cfg
        $error("calc_operand_capture: CNT_W too small or cycle counts below 1");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Synchroniser stages
    logic [7:0]       r_sw_m, r_sw_s;
    logic [2:0]       r_key_m, r_key_s;
    logic             r_ent_m, r_ent_s;

    // Debouncer
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             w_ent_differ;
    logic             w_deb_done;

    // FSM
    state_t           r_state;
    state_t           w_state_nxt;

    // Output registers and their next-cycle controls
    logic [3:0]       r_a, r_b;
    logic [2:0]       r_op;
    logic             r_valid, r_busy;
    logic             w_load;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_rep_fire;

    // Two-flop synchronisers. ENTER resets to 1 so that reset reads as "released".
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_m  <= 8'h00;
            r_sw_s  <= 8'h00;
            r_key_m <= 3'b000;
            r_key_s <= 3'b000;
            r_ent_m <= 1'b1;
            r_ent_s <= 1'b1;
        end else begin
            r_sw_m  <= SW;
            r_sw_s  <= r_sw_m;
            r_key_m <= KEY;
            r_key_s <= r_key_m;
            r_ent_m <= ENTER_N;
            r_ent_s <= r_ent_m;
        end
    end

    // The debounced level follows ENT_S only after it has disagreed for DEBOUNCE_CYCLES edges.
    assign w_ent_differ = (r_ent_s != r_deb);
    assign w_deb_done   = w_ent_differ && (r_cnt == DEB_LAST);

    // Debounce counter. Any agreeing edge restarts the count, so the counter never passes DEB_LAST.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
        end else if (!w_ent_differ) begin
            r_cnt <= '0;
        end else if (w_deb_done) begin
            r_cnt <= '0;
            r_deb <= r_ent_s;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef CALC_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] r_rep_cnt;

    // Repeat interval timer. It runs only while HELD with ENTER still pressed and is zero otherwise.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rep_cnt <= '0;
        end else if ((r_state == ST_HELD) && !r_deb) begin
            if (w_rep_fire) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + CNT_W'(1);
            end
        end else begin
            r_rep_cnt <= '0;
        end
    end

    assign w_rep_fire = (r_state == ST_HELD) && !r_deb && (r_rep_cnt == REP_LAST);
`else
    assign w_rep_fire = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic. A press is a debounced low level; the release is a debounced high level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (!r_deb) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_HELD;
            ST_HELD:    if (r_deb) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode. The decoded controls are registered on the next edge.
    always_comb begin
        w_load      = 1'b0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_CAPTURE: begin
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            ST_HELD: begin
                // Release takes priority over a repeat pulse in the same cycle.
                if (r_deb) begin
                    w_busy_nxt = 1'b0;
                end else if (w_rep_fire) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers. A, B and OP load together from the synchronised inputs, so they are never half-updated.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_a     <= 4'h0;
            r_b     <= 4'h0;
            r_op    <= 3'b000;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            if (w_load) begin
                r_a  <= r_sw_s[7:4];
                r_b  <= r_sw_s[3:0];
                r_op <= r_key_s;
            end
        end
    end

    assign A_OUT  = r_a;
    assign B_OUT  = r_b;
    assign OP_OUT = r_op;
    assign VALID  = r_valid;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_calc_operand_capture.sv
// Testbench for calc_operand_capture. The DUT is built with DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=8.
// Inputs change 1 ns after each falling edge. Outputs are sampled at the
// falling edge. edge_n counts rising edges.
module tb_calc_operand_capture;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [2:0] key = 3'b000;
  logic       enter_n = 1'b1;
  logic [3:0] a_out, b_out;
  logic [2:0] op_out;
  logic       valid, busy;

  int n_pass = 0;
  int n_total = 0;
  int edge_n = 0;
  int valid_cnt = 0;
  int last_valid_edge = -1;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  typedef struct {
    logic [7:0] sw;
    logic [2:0] key;
    logic [7:0] sw_hold;
    logic [2:0] key_hold;
    bit         bounce;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] eop;
  } vec_t;

  vec_t vecs[6];

  calc_operand_capture #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20),
    .REPEAT_CYCLES(R)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .SW(sw),
    .KEY(key),
    .ENTER_N(enter_n),
    .A_OUT(a_out),
    .B_OUT(b_out),
    .OP_OUT(op_out),
    .VALID(valid),
    .BUSY(busy)
  );

  // clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // scoreboard: every VALID pops one expected {A,B,OP}
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      last_valid_edge = edge_n;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got VALID=1 with {A,B,OP}=%0h expected no VALID (edge %0d)",
                 {a_out, b_out, op_out}, edge_n);
      end else begin
        mon_exp = exp_q.pop_front();
        check("capture_abop", {21'd0, a_out, b_out, op_out}, {21'd0, mon_exp});
      end
    end
  end

  initial begin
    int v0;
    int k;
    int j;
    logic [7:0] rs;
    logic [2:0] rk;

    // vector table: random entries first, fixed corners last
    for (int i = 0; i < 3; i++) begin
      rs = 8'($urandom_range(0, 255));
      rk = 3'($urandom_range(0, 7));
      vecs[i] = '{rs, rk, ~rs, ~rk, 1'b0, rs[7:4], rs[3:0], rk};
    end
    vecs[3] = '{8'h7F, 3'b010, 8'h11, 3'b001, 1'b0, 4'h7, 4'hF, 3'b010};
    vecs[4] = '{8'h80, 3'b111, 8'hFF, 3'b000, 1'b1, 4'h8, 4'h0, 3'b111};
    vecs[5] = '{8'b10011111, 3'b101, 8'h00, 3'b000, 1'b1, 4'h9, 4'hF, 3'b101};

    // reset, then idle
    step(3);
    check("reset_outputs", {20'd0, a_out, b_out, op_out, valid, busy}, 32'd0);
    rst_n = 1'b1;
    step(100);
    check("idle_no_valid", valid_cnt, 0);
    check("idle_outputs", {20'd0, a_out, b_out, op_out, valid, busy}, 32'd0);

    // basic press: VALID latency and BUSY release timing
    sw = 8'b01000011;
    key = 3'b000;
    step(1);
    v0 = valid_cnt;
    k = edge_n + 1;
    exp_q.push_back({4'h4, 4'h3, 3'b000});
    enter_n = 1'b0;
    step(40);
`ifndef CALC_REPEAT_EN
    check("press_one_valid", valid_cnt - v0, 1);
    check("press_latency", last_valid_edge, k + D + 3);
`endif
    check("press_busy_held", busy, 1);
    enter_n = 1'b1;
    step(D + 2);
    check("release_busy_still_high", busy, 1);
    step(1);
    check("release_busy_low", busy, 0);
    step(10);
    check("release_outputs_hold", {21'd0, a_out, b_out, op_out}, {21'd0, 4'h4, 4'h3, 3'b000});

    // short bounces (3 cycles, one less than D) never debounce
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) begin
      enter_n = 1'b0;
      step(3);
      enter_n = 1'b1;
      check("bounce_busy_low", busy, 0);
      step(3);
    end
    step(10);
    check("bounce_no_valid", valid_cnt - v0, 0);
    check("bounce_outputs_hold", {21'd0, a_out, b_out, op_out}, {21'd0, 4'h4, 4'h3, 3'b000});

    // table-driven presses: inputs change while held, optional release bounce
    for (int i = 0; i < 6; i++) begin
      sw = vecs[i].sw;
      key = vecs[i].key;
      step(2);
      v0 = valid_cnt;
      exp_q.push_back({vecs[i].ea, vecs[i].eb, vecs[i].eop});
      enter_n = 1'b0;
      step(D + 5);
      sw = vecs[i].sw_hold;
      key = vecs[i].key_hold;
      check("vec_busy_held", busy, 1);
      step(2);
      if (vecs[i].bounce) begin
        for (int b = 0; b < 2; b++) begin
          enter_n = 1'b1;
          step(2);
          enter_n = 1'b0;
          step(2);
        end
        check("vec_busy_after_bounce", busy, 1);
      end
      enter_n = 1'b1;
      step(D + 10);
      check("vec_one_valid", valid_cnt - v0, 1);
      check("vec_outputs_hold", {21'd0, a_out, b_out, op_out},
            {21'd0, vecs[i].ea, vecs[i].eb, vecs[i].eop});
      check("vec_busy_released", busy, 0);
    end

    // reset while the debounce count is 2, ENTER still held through reset release
    sw = 8'h5A;
    key = 3'b011;
    step(2);
    enter_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs_zero", {20'd0, a_out, b_out, op_out, valid, busy}, 32'd0);
    step(3);
    check("midreset_outputs_stay_zero", {20'd0, a_out, b_out, op_out, valid, busy}, 32'd0);
    v0 = valid_cnt;
    rst_n = 1'b1;
    j = edge_n + 1;
    exp_q.push_back({4'h5, 4'hA, 3'b011});
    step(20);
    check("midreset_one_valid", valid_cnt - v0, 1);
    check("midreset_latency", last_valid_edge, j + 7);
    enter_n = 1'b1;
    step(15);
    check("midreset_outputs_hold", {21'd0, a_out, b_out, op_out}, {21'd0, 4'h5, 4'hA, 3'b011});
    check("midreset_busy_released", busy, 0);

    // long hold: VALID count with and without auto-repeat
    sw = 8'h3C;
    key = 3'b110;
    step(2);
    v0 = valid_cnt;
    exp_q.push_back({4'h3, 4'hC, 3'b110});
`ifdef CALC_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back({4'h3, 4'hC, 3'b110});
`endif
    enter_n = 1'b0;
    step(D + 4);
    step(24);
    enter_n = 1'b1;
    step(20);
`ifdef CALC_REPEAT_EN
    check("hold_valid_count", valid_cnt - v0, 4);
`else
    check("hold_valid_count", valid_cnt - v0, 1);
`endif
    check("hold_busy_released", busy, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
